// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, register-file write and decode hazard-query signals
// shared between the arbiter (slave) and its requesters/consumers (master).
interface regfile_wb_arbiter_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
);
    logic            in0_valid;
    logic            in0_ready;
    logic [AW-1:0]   in0_rd;
    logic [XLEN-1:0] in0_data;

    logic            in1_valid;
    logic            in1_ready;
    logic [AW-1:0]   in1_rd;
    logic [XLEN-1:0] in1_data;

    logic            we;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;

    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            rs1_pending;
    logic            rs2_pending;

    modport master (
        output in0_valid, in0_rd, in0_data,
        output in1_valid, in1_rd, in1_data,
        output rs1_addr, rs2_addr,
        input  in0_ready, in1_ready,
        input  we, rd_addr, rd_data,
        input  rs1_pending, rs2_pending
    );

    modport slave (
        input  in0_valid, in0_rd, in0_data,
        input  in1_valid, in1_rd, in1_data,
        input  rs1_addr, rs2_addr,
        output in0_ready, in1_ready,
        output we, rd_addr, rd_data,
        output rs1_pending, rs2_pending
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter: one-entry buffer per port, oldest-first grant with
// round-robin tie-break, registered register-file write stage and hazard flags.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);
    logic [1:0]      r_full;
    logic [AW-1:0]   r_rd    [2];
    logic [XLEN-1:0] r_data  [2];
    logic [1:0]      r_stamp [2];
    logic [1:0]      r_edge;
    logic            r_rr;
    logic            r_we;
    logic [AW-1:0]   r_rd_addr;
    logic [XLEN-1:0] r_rd_data;

    logic [1:0]      w_valid;
    logic [AW-1:0]   w_in_rd   [2];
    logic [XLEN-1:0] w_in_data [2];
    logic [1:0]      w_stamp_diff;
    logic            w_both;
    logic            w_tie;
    logic            w_older0;
    logic [1:0]      w_grant;
    logic [1:0]      w_ready;
    logic [1:0]      w_load;

    assign w_valid      = {bus.in1_valid, bus.in0_valid};
    assign w_in_rd[0]   = bus.in0_rd;
    assign w_in_rd[1]   = bus.in1_rd;
    assign w_in_data[0] = bus.in0_data;
    assign w_in_data[1] = bus.in1_data;

    // A buffer never waits more than one extra cycle, so two live stamps differ by
    // at most one edge and a 2-bit modular difference orders them unambiguously.
    always_comb begin
        w_both       = &r_full;
        w_stamp_diff = r_stamp[0] - r_stamp[1];
        w_tie        = w_both && (w_stamp_diff == 2'b00);
        w_older0     = (w_stamp_diff == 2'b11);
        w_grant      = r_full;
        if (w_both) begin
            if (w_tie) begin
                w_grant = r_rr ? 2'b10 : 2'b01;
            end else if (w_older0) begin
                w_grant = 2'b01;
            end else begin
                w_grant = 2'b10;
            end
        end
    end

    always_comb begin
        w_ready = ~r_full | w_grant;
        w_load  = '0;
        for (int p = 0; p < 2; p++) begin
            w_load[p] = w_valid[p] && w_ready[p] && (w_in_rd[p] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full    <= '0;
            r_edge    <= '0;
            r_rr      <= 1'b0;
            r_we      <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
            for (int p = 0; p < 2; p++) begin
                r_rd[p]    <= '0;
                r_data[p]  <= '0;
                r_stamp[p] <= '0;
            end
        end else begin
            r_edge <= r_edge + 2'd1;
            if (w_tie) begin
                r_rr <= ~r_rr;
            end
            r_we <= |w_grant;
            if (w_grant[0]) begin
                r_rd_addr <= r_rd[0];
                r_rd_data <= r_data[0];
            end else if (w_grant[1]) begin
                r_rd_addr <= r_rd[1];
                r_rd_data <= r_data[1];
            end
            // A granted buffer may be refilled on the same edge it drains.
            for (int p = 0; p < 2; p++) begin
                if (w_load[p]) begin
                    r_full[p]  <= 1'b1;
                    r_rd[p]    <= w_in_rd[p];
                    r_data[p]  <= w_in_data[p];
                    r_stamp[p] <= r_edge;
                end else if (w_grant[p]) begin
                    r_full[p]  <= 1'b0;
                end
            end
        end
    end

    assign bus.in0_ready = w_ready[0];
    assign bus.in1_ready = w_ready[1];
    assign bus.we        = r_we;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.rd_data   = r_rd_data;

    assign bus.rs1_pending = (bus.rs1_addr != '0) &&
        ((r_full[0] && (r_rd[0] == bus.rs1_addr)) ||
         (r_full[1] && (r_rd[1] == bus.rs1_addr)) ||
         (r_we && (r_rd_addr == bus.rs1_addr)));

    assign bus.rs2_pending = (bus.rs2_addr != '0) &&
        ((r_full[0] && (r_rd[0] == bus.rs2_addr)) ||
         (r_full[1] && (r_rd[1] == bus.rs2_addr)) ||
         (r_we && (r_rd_addr == bus.rs2_addr)));

`ifndef SYNTHESIS
    a_stamp_window: assert property (@(posedge clk) disable iff (rst)
        w_both |-> (w_stamp_diff != 2'b10));
    a_single_grant: assert property (@(posedge clk) disable iff (rst) $onehot0(w_grant));
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter: a cycle-level model of the
// arbitration rules feeds a scoreboard that a separate monitor drains.
module tb_regfile_wb_arbiter;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef struct {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.XLEN(XLEN), .AW(AW)) bus ();
    regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    wr_t exp_q[$];
    wr_t src0_q[$];
    wr_t src1_q[$];

    // Reference model: each port holds at most one request tagged with the cycle
    // number it was accepted in; the lowest cycle number wins, ties alternate.
    bit              m_full [2];
    logic [AW-1:0]   m_rd   [2];
    logic [XLEN-1:0] m_dat  [2];
    int              m_age  [2];
    bit              m_rr;
    bit              m_we;
    logic [AW-1:0]   m_wa;
    logic [XLEN-1:0] m_wd;
    int              cyc;
    logic [XLEN-1:0] model_rf [32];
    logic [XLEN-1:0] dut_rf   [32];
    bit              gaps;
    bit              rand_rs;
    int              we_run;
    int              we_run_max;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_pend(input logic [AW-1:0] a);
        return (a != 0) && ((m_full[0] && m_rd[0] == a) || (m_full[1] && m_rd[1] == a) ||
                            (m_we && m_wa == a));
    endfunction

    task automatic step();
        bit  v[2];
        bit  rdy[2];
        wr_t it[2];
        int  g;
        @(negedge clk);
        v[0] = (src0_q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
        v[1] = (src1_q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
        it[0] = v[0] ? src0_q[0] : '{rd: AW'($urandom), data: $urandom};
        it[1] = v[1] ? src1_q[0] : '{rd: AW'($urandom), data: $urandom};
        bus.in0_valid = v[0];
        bus.in0_rd    = it[0].rd;
        bus.in0_data  = it[0].data;
        bus.in1_valid = v[1];
        bus.in1_rd    = it[1].rd;
        bus.in1_data  = it[1].data;
        if (rand_rs) begin
            bus.rs1_addr = AW'($urandom_range(0, 7));
            bus.rs2_addr = AW'($urandom_range(0, 7));
        end
        #1;
        if (bus.we) dut_rf[bus.rd_addr] = bus.rd_data;
        if (bus.we) we_run++;
        else we_run = 0;
        if (we_run > we_run_max) we_run_max = we_run;

        g = -1;
        if (m_full[0] && m_full[1]) begin
            if (m_age[0] < m_age[1]) g = 0;
            else if (m_age[1] < m_age[0]) g = 1;
            else begin
                g    = int'(m_rr);
                m_rr = !m_rr;
            end
        end else if (m_full[0]) g = 0;
        else if (m_full[1]) g = 1;
        rdy[0] = !m_full[0] || g == 0;
        rdy[1] = !m_full[1] || g == 1;

        check("in0_ready", 64'(bus.in0_ready), 64'(rdy[0]));
        check("in1_ready", 64'(bus.in1_ready), 64'(rdy[1]));
        check("we", 64'(bus.we), 64'(m_we));
        check("rs1_pending", 64'(bus.rs1_pending), 64'(m_pend(bus.rs1_addr)));
        check("rs2_pending", 64'(bus.rs2_pending), 64'(m_pend(bus.rs2_addr)));

        if (m_we) model_rf[m_wa] = m_wd;
        if (g >= 0) begin
            exp_q.push_back('{rd: m_rd[g], data: m_dat[g]});
            m_we      = 1'b1;
            m_wa      = m_rd[g];
            m_wd      = m_dat[g];
            m_full[g] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            if (v[p] && rdy[p]) begin
                if (it[p].rd != 0) begin
                    m_full[p] = 1'b1;
                    m_rd[p]   = it[p].rd;
                    m_dat[p]  = it[p].data;
                    m_age[p]  = cyc;
                end
                if (p == 0) void'(src0_q.pop_front());
                else void'(src1_q.pop_front());
            end
        end
        cyc++;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((src0_q.size() > 0 || src1_q.size() > 0 || m_full[0] || m_full[1] || m_we) &&
               n < bound) begin
            step();
            n++;
        end
        check("drain_in_time", 64'(n < bound), 64'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_we"}, 64'(bus.we), 64'd0);
        check({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
        check({tag, "_rd_data"}, 64'(bus.rd_data), 64'd0);
        check({tag, "_in0_ready"}, 64'(bus.in0_ready), 64'd1);
        check({tag, "_in1_ready"}, 64'(bus.in1_ready), 64'd1);
        check({tag, "_rs1_pending"}, 64'(bus.rs1_pending), 64'd0);
        check({tag, "_rs2_pending"}, 64'(bus.rs2_pending), 64'd0);
    endtask

    task automatic model_clear();
        m_full = '{0, 0};
        m_we   = 1'b0;
        m_wa   = '0;
        m_wd   = '0;
        m_rr   = 1'b0;
        exp_q.delete();
    endtask

    // Scoreboard monitor: every DUT write must match the next expected write.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!rst && bus.we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_write actual rd=%0d data=%0h expected none",
                             bus.rd_addr, bus.rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_rd", 64'(bus.rd_addr), 64'(e.rd));
                    check("wr_data", 64'(bus.rd_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        int bad;
        bus.in0_valid = 0; bus.in0_rd = '0; bus.in0_data = '0;
        bus.in1_valid = 0; bus.in1_rd = '0; bus.in1_data = '0;
        bus.rs1_addr  = '0; bus.rs2_addr = '0;
        for (int i = 0; i < 32; i++) begin
            model_rf[i] = '0;
            dut_rf[i]   = '0;
        end
        model_clear();
        cyc = 0; gaps = 0; rand_rs = 0; we_run = 0; we_run_max = 0;

        repeat (2) @(negedge clk);
        #1;
        check_reset_state("por");
        @(negedge clk);
        rst = 1'b0;

        // Single port write with hazard query on the destination.
        bus.rs1_addr = 5'd5;
        bus.rs2_addr = 5'd0;
        src0_q.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
        drain(20);

        // Simultaneous streams from both ports.
        bus.rs1_addr = 5'd1;
        bus.rs2_addr = 5'd11;
        for (int i = 1; i <= 4; i++) begin
            src0_q.push_back('{rd: AW'(i), data: 32'h100 + i});
            src1_q.push_back('{rd: AW'(i + 10), data: 32'h200 + i});
        end
        drain(40);

        // Same destination from both ports: earlier acceptance must land first.
        bus.rs1_addr = 5'd7;
        src0_q.push_back('{rd: 5'd3, data: 32'h33});
        src0_q.push_back('{rd: 5'd7, data: 32'hB});
        src1_q.push_back('{rd: 5'd7, data: 32'hA});
        drain(40);
        check("age_x7_final", 64'(dut_rf[7]), 64'h0000_000B);

        // Writes to x0 are swallowed.
        bus.rs1_addr = 5'd0;
        src1_q.push_back('{rd: 5'd0, data: 32'h123});
        drain(20);
        check("x0_untouched", 64'(dut_rf[0]), 64'd0);

        // Back-to-back stream on port 0 alone.
        we_run_max = 0;
        for (int i = 0; i < 8; i++) src0_q.push_back('{rd: AW'(16 + i), data: $urandom});
        drain(40);
        check("tput_run", 64'(we_run_max), 64'd8);

        // Asynchronous reset with both buffers occupied.
        for (int i = 0; i < 6; i++) begin
            src0_q.push_back('{rd: AW'(20 + i), data: $urandom});
            src1_q.push_back('{rd: AW'(26 + i % 4), data: $urandom});
        end
        repeat (3) step();
        @(posedge clk);
        #3;
        bus.rs1_addr  = m_rd[0];
        bus.rs2_addr  = m_rd[1];
        bus.in0_valid = 0;
        bus.in1_valid = 0;
        rst = 1'b1;
        #1;
        check_reset_state("mid");
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drain(60);

        // Randomized traffic with bubbles and random hazard queries.
        gaps    = 1;
        rand_rs = 1;
        for (int i = 0; i < 200; i++) begin
            src0_q.push_back('{rd: AW'($urandom_range(0, 9)), data: $urandom});
            src1_q.push_back('{rd: AW'($urandom_range(0, 9)), data: $urandom});
        end
        drain(3000);
        repeat (3) step();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        bad = 0;
        for (int i = 0; i < 32; i++) if (dut_rf[i] !== model_rf[i]) bad++;
        check("regfile_contents", 64'(bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
